// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Accepts one ALU command at a time, holds its operands/opcode/select on the
// ALU-facing outputs, waits the opcode's execution latency, captures the
// combinational ALU result and flags, and presents them as a response held
// until consumed. Illegal opcodes and divide-by-zero skip execution and
// answer immediately with an error response.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_a, cmd_b, cmd_opcode    operands and opcode
//   cmd_sel                     implementation select for the opcode's unit
//   alu_A, alu_B, alu_opcode    held operands/opcode driven to the ALU
//   alu_*_sel                   held per-unit implementation selects
//   alu_result, alu_zero/carry/overflow/sign   combinational ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_flags, rsp_err   captured response ({z,c,v,s} flags)
//   op_count, err_count         saturating completed / errored response counts
//
// All latency parameters must be at least 1.
module alu_op_sequencer #(
    parameter int WIDTH    = 32,
    parameter int BASE_LAT = 1,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_opcode,
    input  logic [1:0]       cmd_sel,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_opcode,
    output logic [1:0]       alu_adder_sel,
    output logic [1:0]       alu_sub_sel,
    output logic [1:0]       alu_mul_sel,
    output logic [1:0]       alu_div_sel,
    output logic [1:0]       alu_shifter_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [15:0]      op_count,
    output logic [15:0]      err_count
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ?
                             ((DIV_LAT > BASE_LAT) ? DIV_LAT : BASE_LAT) :
                             ((MUL_LAT > BASE_LAT) ? MUL_LAT : BASE_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               legal_s;
    logic               div_zero_s;
    logic [WIDTH-1:0]   alu_a_r;
    logic [WIDTH-1:0]   alu_b_r;
    logic [3:0]         alu_opcode_r;
    logic [1:0]         adder_sel_r;
    logic [1:0]         sub_sel_r;
    logic [1:0]         mul_sel_r;
    logic [1:0]         div_sel_r;
    logic [1:0]         shifter_sel_r;
    logic [WIDTH-1:0]   rsp_result_r;
    logic [3:0]         rsp_flags_r;
    logic               rsp_err_r;
    logic [15:0]        op_count_r;
    logic [15:0]        err_count_r;

    // Opcodes 0000-0110, 1001 (mul) and 1010 (div) are implemented.
    function automatic logic is_legal(input logic [3:0] op);
        is_legal = (op <= 4'b0110) || (op == 4'b1001) || (op == 4'b1010);
    endfunction

    // Counter preload: the EXEC state lasts (value + 1) cycles.
    function automatic logic [CNT_W-1:0] lat_load(input logic [3:0] op);
        case (op)
            4'b1001: lat_load = CNT_W'(MUL_LAT - 1);
            4'b1010: lat_load = CNT_W'(DIV_LAT - 1);
            default: lat_load = CNT_W'(BASE_LAT - 1);
        endcase
    endfunction

    // Decode of the offered command used by both FSM and datapath.
    always_comb begin
        legal_s    = is_legal(cmd_opcode);
        div_zero_s = (cmd_opcode == 4'b1010) && (cmd_b == {WIDTH{1'b0}});
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; error commands go straight to RESP.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (!legal_s || div_zero_s) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: command capture, latency countdown, response capture, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r         <= {CNT_W{1'b0}};
            alu_a_r       <= {WIDTH{1'b0}};
            alu_b_r       <= {WIDTH{1'b0}};
            alu_opcode_r  <= 4'b0000;
            adder_sel_r   <= 2'b00;
            sub_sel_r     <= 2'b00;
            mul_sel_r     <= 2'b00;
            div_sel_r     <= 2'b00;
            shifter_sel_r <= 2'b00;
            rsp_result_r  <= {WIDTH{1'b0}};
            rsp_flags_r   <= 4'b0000;
            rsp_err_r     <= 1'b0;
            op_count_r    <= 16'h0000;
            err_count_r   <= 16'h0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        alu_a_r      <= cmd_a;
                        alu_b_r      <= cmd_b;
                        alu_opcode_r <= cmd_opcode;
                        // Only the unit serving this opcode takes the new select.
                        case (cmd_opcode)
                            4'b0000: adder_sel_r   <= cmd_sel;
                            4'b0001: sub_sel_r     <= cmd_sel;
                            4'b0110: shifter_sel_r <= cmd_sel;
                            4'b1001: mul_sel_r     <= cmd_sel;
                            4'b1010: div_sel_r     <= cmd_sel;
                            default: ;
                        endcase
                        cnt_r <= lat_load(cmd_opcode);
                        if (!legal_s) begin
                            rsp_result_r <= {WIDTH{1'b0}};
                            rsp_flags_r  <= 4'b1000;
                            rsp_err_r    <= 1'b1;
                        end else if (div_zero_s) begin
                            rsp_result_r <= {WIDTH{1'b1}};
                            rsp_flags_r  <= 4'b0001;
                            rsp_err_r    <= 1'b1;
                        end else begin
                            rsp_err_r    <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        rsp_result_r <= alu_result;
                        rsp_flags_r  <= {alu_zero, alu_carry, alu_overflow, alu_sign};
                        rsp_err_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (op_count_r != 16'hFFFF) begin
                            op_count_r <= op_count_r + 16'd1;
                        end
                        if (rsp_err_r && (err_count_r != 16'hFFFF)) begin
                            err_count_r <= err_count_r + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready       = (state_r == ST_IDLE);
    assign rsp_valid       = (state_r == ST_RESP);
    assign alu_A           = alu_a_r;
    assign alu_B           = alu_b_r;
    assign alu_opcode      = alu_opcode_r;
    assign alu_adder_sel   = adder_sel_r;
    assign alu_sub_sel     = sub_sel_r;
    assign alu_mul_sel     = mul_sel_r;
    assign alu_div_sel     = div_sel_r;
    assign alu_shifter_sel = shifter_sel_r;
    assign rsp_result      = rsp_result_r;
    assign rsp_flags       = rsp_flags_r;
    assign rsp_err         = rsp_err_r;
    assign op_count        = op_count_r;
    assign err_count       = err_count_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a small behavioural ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_opcode;
    logic [1:0]  cmd_sel;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_opcode;
    logic [1:0]  alu_adder_sel;
    logic [1:0]  alu_sub_sel;
    logic [1:0]  alu_mul_sel;
    logic [1:0]  alu_div_sel;
    logic [1:0]  alu_shifter_sel;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] op_count;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_sel(cmd_sel),
        .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
        .alu_adder_sel(alu_adder_sel), .alu_sub_sel(alu_sub_sel),
        .alu_mul_sel(alu_mul_sel), .alu_div_sel(alu_div_sel),
        .alu_shifter_sel(alu_shifter_sel),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .op_count(op_count), .err_count(err_count)
    );

    // Behavioural ALU fed by the held operands.
    always_comb begin
        logic [32:0] wide;
        wide = 33'd0;
        case (alu_opcode)
            4'b0000: wide = {1'b0, alu_A} + {1'b0, alu_B};
            4'b0001: wide = {1'b0, alu_A} - {1'b0, alu_B};
            4'b0010: wide = {1'b0, alu_A & alu_B};
            4'b0011: wide = {1'b0, alu_A | alu_B};
            4'b0100: wide = {1'b0, alu_A ^ alu_B};
            4'b0101: wide = {1'b0, ~alu_A};
            4'b0110: wide = {1'b0, alu_A << alu_B[4:0]};
            4'b1001: wide = {1'b0, alu_A * alu_B};
            4'b1010: wide = (alu_B != 32'd0) ? {1'b0, alu_A / alu_B} : 33'd0;
            default: wide = 33'd0;
        endcase
        alu_result   = wide[31:0];
        alu_carry    = wide[32];
        alu_zero     = (wide[31:0] == 32'd0);
        alu_sign     = wide[31];
        alu_overflow = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a command at a negedge; it is accepted on the following posedge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [1:0] sel);
        @(negedge clk);
        chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_sel = sel; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Count posedges, including the accepting one, until rsp_valid is seen.
    task automatic wait_rsp(output int l);
        l = 1;
        while (rsp_valid !== 1'b1 && l < 64) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = 32'd0; cmd_b = 32'd0; cmd_opcode = 4'd0; cmd_sel = 2'd0;
        #12;
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_alu_A",     alu_A, 32'd0);
        chk("reset_op_count",  {16'd0, op_count}, 32'd0);
        chk("reset_err_count", {16'd0, err_count}, 32'd0);
        rst_n = 1'b1;

        // ADD
        send(32'h0000000A, 32'h00000005, 4'b0000, 2'b01);
        wait_rsp(lat);
        chk("add_latency", lat, 32'd2);
        chk("add_result",  rsp_result, 32'h0000000F);
        chk("add_flags",   {28'd0, rsp_flags}, 32'h0);
        chk("add_err",     {31'd0, rsp_err}, 32'd0);
        chk("add_adder_sel", {30'd0, alu_adder_sel}, 32'd1);
        consume();
        chk("add_op_count", {16'd0, op_count}, 32'd1);
        chk("add_idle", {31'd0, cmd_ready}, 32'd1);

        // SUB with borrow: 5 - 7
        send(32'd5, 32'd7, 4'b0001, 2'b10);
        wait_rsp(lat);
        chk("sub_latency", lat, 32'd2);
        chk("sub_result",  rsp_result, 32'hFFFFFFFE);
        chk("sub_flags",   {28'd0, rsp_flags}, 32'h5);
        chk("sub_sub_sel", {30'd0, alu_sub_sel}, 32'd2);
        chk("sub_adder_sel_kept", {30'd0, alu_adder_sel}, 32'd1);
        consume();

        // MUL with cmd_valid offered during EXEC and RESP
        send(32'd3, 32'd7, 4'b1001, 2'b11);
        cmd_valid = 1'b1; cmd_a = 32'd99; cmd_opcode = 4'b0000;
        wait_rsp(lat);
        chk("mul_latency", lat, 32'd5);
        chk("mul_result",  rsp_result, 32'h00000015);
        chk("mul_opcode_held", {28'd0, alu_opcode}, 32'h9);
        chk("mul_a_held",  alu_A, 32'd3);
        chk("mul_mul_sel", {30'd0, alu_mul_sel}, 32'd3);
        cmd_valid = 1'b0;
        consume();

        // DIV full latency
        send(32'd64, 32'd8, 4'b1010, 2'b01);
        wait_rsp(lat);
        chk("div_latency", lat, 32'd33);
        chk("div_result",  rsp_result, 32'd8);
        chk("div_err",     {31'd0, rsp_err}, 32'd0);
        consume();

        // DIV by zero
        send(32'd64, 32'd0, 4'b1010, 2'b10);
        wait_rsp(lat);
        chk("div0_latency", lat, 32'd1);
        chk("div0_result",  rsp_result, 32'hFFFFFFFF);
        chk("div0_flags",   {28'd0, rsp_flags}, 32'h1);
        chk("div0_err",     {31'd0, rsp_err}, 32'd1);
        chk("div0_div_sel", {30'd0, alu_div_sel}, 32'd2);
        consume();
        chk("div0_err_count", {16'd0, err_count}, 32'd1);

        // Illegal opcode, response held while rsp_ready stays low
        send(32'd1, 32'd2, 4'b0111, 2'b11);
        wait_rsp(lat);
        chk("ill_latency", lat, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("ill_hold_valid",  {31'd0, rsp_valid}, 32'd1);
            chk("ill_hold_result", rsp_result, 32'd0);
            chk("ill_hold_flags",  {28'd0, rsp_flags}, 32'h8);
            chk("ill_hold_err",    {31'd0, rsp_err}, 32'd1);
        end
        chk("ill_sels_kept", {22'd0, alu_adder_sel, alu_sub_sel, alu_mul_sel,
                              alu_div_sel, alu_shifter_sel}, {22'd0, 10'b01_10_11_10_00});
        consume();
        chk("ops_op_count",  {16'd0, op_count}, 32'd6);
        chk("ops_err_count", {16'd0, err_count}, 32'd2);

        // Reset during DIV, in EXEC cycle 10
        send(32'd64, 32'd8, 4'b1010, 2'b11);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_op_count",  {16'd0, op_count}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("rst_alu_B", alu_B, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        send(32'h0000000A, 32'h00000005, 4'b0000, 2'b01);
        wait_rsp(lat);
        chk("post_rst_latency", lat, 32'd2);
        chk("post_rst_result",  rsp_result, 32'h0000000F);
        consume();
        chk("post_rst_op_count", {16'd0, op_count}, 32'd1);

        // Saturation: preload counters close to the top, then run error ops
        @(negedge clk);
        force dut.op_count_r  = 16'hFFFC;
        force dut.err_count_r = 16'hFFFD;
        #1;
        release dut.op_count_r;
        release dut.err_count_r;
        for (int i = 0; i < 5; i++) begin
            send(32'd0, 32'd0, 4'b1111, 2'b00);
            wait_rsp(lat);
            consume();
        end
        chk("sat_op_count",  {16'd0, op_count}, 32'h0000FFFF);
        chk("sat_err_count", {16'd0, err_count}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 32, operand and result width
- BASE_LAT, 1, EXEC cycles for opcodes 0000-0110
- MUL_LAT, 4, EXEC cycles for opcode 1001
- DIV_LAT, 32, EXEC cycles for opcode 1010
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_a, cmd_b  in  WIDTH  operands
- cmd_opcode  in  4  ALU opcode
- cmd_sel  in  2  implementation select for the opcode's unit
- alu_A, alu_B  out  WIDTH  held operands to the ALU
- alu_opcode  out  4  held opcode
- alu_adder_sel, alu_sub_sel, alu_mul_sel, alu_div_sel, alu_shifter_sel  out  2 each  held selects
- alu_result  in  WIDTH  combinational ALU result
- alu_zero, alu_carry, alu_overflow, alu_sign  in  1 each  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_result  out  WIDTH  captured result
- rsp_flags  out  4  {zero, carry, overflow, sign} captured
- rsp_err  out  1  illegal opcode or divide-by-zero
- op_count, err_count  out  16 each  saturating completed/errored response counters
REQ-003 Clock and reset SHALL be exactly: one clock; reset is asynchronous and active-low, ports clk and rst_n.

Function
REQ-004 FSM states SHALL be IDLE, EXEC, RESP; cmd_ready=1 only in IDLE; rsp_valid=1 only in RESP.
REQ-005 IDLE with cmd_valid SHALL register cmd_a, cmd_b, cmd_opcode onto alu_A/alu_B/alu_opcode and cmd_sel onto the select of the opcode's unit only (0000 adder, 0001 sub, 0110 shifter, 1001 mul, 1010 div); other selects keep value.
REQ-006 Legal opcodes SHALL be 0000-0110, 1001, 1010; accepted legal non-error command loads down-counter with BASE_LAT-1, MUL_LAT-1 or DIV_LAT-1 and enters EXEC.
REQ-007 EXEC SHALL decrement the counter each cycle; in the cycle counter==0 it SHALL capture alu_result and flags into rsp_result/rsp_flags, rsp_err=0, and enter RESP; command-to-rsp_valid latency is 1+LAT cycles.
REQ-008 Illegal opcode SHALL bypass EXEC: next cycle RESP with rsp_result=0, rsp_flags=4'b1000, rsp_err=1.
REQ-009 Opcode 1010 with cmd_b==0 SHALL bypass EXEC: next cycle RESP with rsp_result all ones, rsp_flags=4'b0001, rsp_err=1.
REQ-010 alu_* outputs SHALL remain stable from acceptance until the next acceptance.
REQ-011 RESP SHALL hold rsp_* stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE, increment op_count, and increment err_count if rsp_err; both saturate at 16'hFFFF.
REQ-012 No new command SHALL be accepted in the RESP->IDLE transfer cycle; cmd_valid during EXEC/RESP SHALL be ignored.
REQ-013 Counter width SHALL be $clog2 of max latency +1; latencies of 0 are illegal parameter values.

Reset
REQ-014 rst_n low SHALL asynchronously force IDLE, counter 0, all alu_* outputs 0, rsp_result 0, rsp_flags 0, rsp_err 0, op_count 0, err_count 0; an in-flight operation is discarded with no response.
REQ-015 First command SHALL be acceptable on the first rising edge after rst_n deasserts.

Verification
REQ-016 ADD: a=0000000A, b=00000005, opcode 0000, sel 01, alu model -> rsp_valid 2 cycles after accept, rsp_result 0000000F, flags 0000, alu_adder_sel=01.
REQ-017 MUL: a=3, b=7, opcode 1001 -> rsp_valid exactly 5 cycles after accept, rsp_result 00000015; cmd_valid pulses during EXEC not accepted.
REQ-018 DIV by zero: a=64, b=0, opcode 1010 -> rsp_valid next cycle, rsp_result FFFFFFFF, rsp_err 1, err_count +1.
REQ-019 Illegal opcode 0111 -> rsp_result 0, rsp_flags 1000, rsp_err 1; rsp_ready held low 10 cycles -> outputs stable throughout.
REQ-020 rst_n asserted mid-DIV (cycle 10 of EXEC) -> immediate IDLE, rsp_valid 0, counters 0; post-reset ADD completes normally.
REQ-021 65540 back-to-back completed ops -> op_count saturates at FFFF.
